// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
//   Types and helpers shared by the alarm bank and the time-keeping counters.
//   - bcd8_t          : two-digit packed BCD value
//   - BCD_*_MAX/NOON  : wrap limits for hours/minutes and the noon constant
//   - alarm_state_t   : ring controller states
//   - to_12h()        : 24h BCD hour -> {pm_flag, 12h BCD hour}
// -----------------------------------------------------------------------------
package alarm_pkg;

   typedef logic [7:0] bcd8_t;

   localparam bcd8_t BCD_HOUR_MAX = 8'h23;
   localparam bcd8_t BCD_MIN_MAX  = 8'h59;
   localparam bcd8_t BCD_NOON     = 8'h12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_t;

   // Returns {pm, hour}. Midnight shows as 12 AM, noon as 12 PM, and the
   // afternoon hours are folded down by twelve and re-encoded as BCD.
   function automatic logic [8:0] to_12h(input bcd8_t h);
      logic [6:0] bin;
      logic [6:0] r;
      logic [8:0] res;
      bin = 7'(h[7:4]) * 7'd10 + 7'(h[3:0]);
      r   = 7'd0;
      if (bin == 7'd0) begin
         res = {1'b0, BCD_NOON};
      end else if (bin < 7'd12) begin
         res = {1'b0, h};
      end else if (bin == 7'd12) begin
         res = {1'b1, BCD_NOON};
      end else begin
         r = bin - 7'd12;
         if (r >= 7'd10) res = {1'b1, 4'd1, 4'(r - 7'd10)};
         else            res = {1'b1, 4'd0, r[3:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_wrap_inc.sv
// -----------------------------------------------------------------------------
// bcd_wrap_inc
//   Combinational two-digit BCD increment; MAX wraps to 8'h00.
//   Ports:
//     d : bcd8_t input value (assumed valid BCD, <= MAX)
//     q : bcd8_t d + 1, or 8'h00 when d == MAX
// -----------------------------------------------------------------------------
module bcd_wrap_inc
   import alarm_pkg::*;
#(
   parameter bcd8_t MAX = 8'h59
) (
   input  bcd8_t d,
   output bcd8_t q
);

   always_comb begin
      q = 8'h00;
      if (d == MAX) begin
         q = 8'h00;
      end else if (d[3:0] == 4'h9) begin
         q = {d[7:4] + 4'd1, 4'h0};
      end else begin
         q = {d[7:4], d[3:0] + 4'd1};
      end
   end

endmodule

// File: rtl/alarm_bank.sv
// -----------------------------------------------------------------------------
// alarm_bank
//   Multi-alarm store with BCD editing, 24h/12h display of the selected alarm,
//   and a ring controller (IDLE/RING, plus SNOOZE when ALARM_SNOOZE_EN is
//   defined; without the macro the Snooze input is ignored).
//   Ports:
//     Clk, RST            : clock, synchronous active-high reset
//     EN, Sel             : edit enable, alarm index for edit/display
//     Btn_Hour, Btn_Min   : debounced levels, rising edge = +1
//     Arm                 : per-alarm arm mask
//     Mode                : 0 = 24h display, 1 = 12h display
//     CurHour, CurMin     : current time (BCD)
//     MinTick             : one-cycle pulse on each minute change
//     Stop, Snooze        : levels, rising edge acts
//     AlertHour/AlertMin  : selected alarm (BCD), APM = PM flag in 12h mode
//     Ring, RingId        : buzzer enable and the alarm that caused it
//     dbg_state           : current ring controller state
// -----------------------------------------------------------------------------
module alarm_bank
   import alarm_pkg::*;
#(
   parameter int N_ALARMS   = 4,
   parameter int SEL_W      = 2,
   parameter int RING_MIN   = 1,
   parameter int SNOOZE_MIN = 5
) (
   input  logic                Clk,
   input  logic                RST,
   input  logic                EN,
   input  logic [SEL_W-1:0]    Sel,
   input  logic                Btn_Hour,
   input  logic                Btn_Min,
   input  logic [N_ALARMS-1:0] Arm,
   input  logic                Mode,
   input  logic [7:0]          CurHour,
   input  logic [7:0]          CurMin,
   input  logic                MinTick,
   input  logic                Stop,
   input  logic                Snooze,
   output logic [7:0]          AlertHour,
   output logic [7:0]          AlertMin,
   output logic                APM,
   output logic                Ring,
   output logic [SEL_W-1:0]    RingId,
   output alarm_state_t        dbg_state
);

   // ---------------------------------------------------------------- edges
   logic hour_q, min_q, stop_q;
   logic hour_edge, min_edge, stop_edge;

   assign hour_edge = Btn_Hour & ~hour_q;
   assign min_edge  = Btn_Min  & ~min_q;
   assign stop_edge = Stop     & ~stop_q;

`ifdef ALARM_SNOOZE_EN
   logic snooze_q, snooze_edge;
   assign snooze_edge = Snooze & ~snooze_q;
`else
   logic snooze_unused;
   assign snooze_unused = Snooze;
`endif

   always_ff @(posedge Clk) begin
      if (RST) begin
         hour_q <= 1'b0;
         min_q  <= 1'b0;
         stop_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         snooze_q <= 1'b0;
`endif
      end else begin
         hour_q <= Btn_Hour;
         min_q  <= Btn_Min;
         stop_q <= Stop;
`ifdef ALARM_SNOOZE_EN
         snooze_q <= Snooze;
`endif
      end
   end

   // ---------------------------------------------------------------- storage
   bcd8_t hour_r [N_ALARMS];
   bcd8_t min_r  [N_ALARMS];
   logic  sel_ok;
   bcd8_t sel_hour, sel_min, hour_inc, min_inc;

   // Out-of-range Sel leaves sel_ok low and reads zeros, which also blocks edits.
   always_comb begin
      sel_ok   = 1'b0;
      sel_hour = 8'h00;
      sel_min  = 8'h00;
      for (int i = 0; i < N_ALARMS; i++) begin
         if (Sel == SEL_W'(i)) begin
            sel_ok   = 1'b1;
            sel_hour = hour_r[i];
            sel_min  = min_r[i];
         end
      end
   end

   bcd_wrap_inc #(.MAX(BCD_HOUR_MAX)) u_hour_inc (.d(sel_hour), .q(hour_inc));
   bcd_wrap_inc #(.MAX(BCD_MIN_MAX))  u_min_inc  (.d(sel_min),  .q(min_inc));

   // Minute wrap never carries into the hour; both buttons may land together.
   always_ff @(posedge Clk) begin
      if (RST) begin
         for (int i = 0; i < N_ALARMS; i++) begin
            hour_r[i] <= 8'h00;
            min_r[i]  <= 8'h00;
         end
      end else if (EN) begin
         for (int i = 0; i < N_ALARMS; i++) begin
            if (Sel == SEL_W'(i)) begin
               if (hour_edge) hour_r[i] <= hour_inc;
               if (min_edge)  min_r[i]  <= min_inc;
            end
         end
      end
   end

   // ---------------------------------------------------------------- display
   logic [8:0] h12;

   always_comb begin
      h12       = to_12h(sel_hour);
      AlertMin  = sel_min;
      AlertHour = 8'h00;
      APM       = 1'b0;
      if (sel_ok) begin
         if (Mode) {APM, AlertHour} = h12;
         else      AlertHour        = sel_hour;
      end
   end

   // ---------------------------------------------------------------- match
   logic             match_hit;
   logic [SEL_W-1:0] match_id;
   logic [SEL_W-1:0] ring_id_r, ring_id_n;
   logic             armed;

   // Scan downward so the lowest matching index is the one left standing.
   always_comb begin
      match_hit = 1'b0;
      match_id  = '0;
      for (int i = N_ALARMS - 1; i >= 0; i--) begin
         if (Arm[i] && (hour_r[i] == CurHour) && (min_r[i] == CurMin)) begin
            match_hit = 1'b1;
            match_id  = SEL_W'(i);
         end
      end
   end

   always_comb begin
      armed = 1'b0;
      for (int i = 0; i < N_ALARMS; i++) begin
         if (ring_id_r == SEL_W'(i)) armed = Arm[i];
      end
   end

   // ---------------------------------------------------------------- ring FSM
   alarm_state_t state_r, state_n;
   logic [3:0]   ring_cnt_r, ring_cnt_n;
   logic         ring_r;
`ifdef ALARM_SNOOZE_EN
   logic [3:0]   snz_cnt_r, snz_cnt_n;
`endif

   always_comb begin
      state_n    = state_r;
      ring_cnt_n = ring_cnt_r;
      ring_id_n  = ring_id_r;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_n  = snz_cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (MinTick && match_hit) begin
               state_n    = RING;
               ring_cnt_n = 4'(RING_MIN);
               ring_id_n  = match_id;
            end
         end
         RING: begin
            // Dismissal (Stop or disarm) outranks snooze and the minute tick.
            if (stop_edge || !armed) begin
               state_n = IDLE;
`ifdef ALARM_SNOOZE_EN
            end else if (snooze_edge) begin
               state_n   = SNOOZE;
               snz_cnt_n = 4'(SNOOZE_MIN);
`endif
            end else if (MinTick) begin
               ring_cnt_n = ring_cnt_r - 4'd1;
               if (ring_cnt_r <= 4'd1) state_n = IDLE;
            end
         end
`ifdef ALARM_SNOOZE_EN
         SNOOZE: begin
            if (stop_edge || !armed) begin
               state_n = IDLE;
            end else if (MinTick) begin
               snz_cnt_n = snz_cnt_r - 4'd1;
               if (snz_cnt_r <= 4'd1) begin
                  state_n    = RING;
                  ring_cnt_n = 4'(RING_MIN);
               end
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (RST) begin
         state_r    <= IDLE;
         ring_cnt_r <= 4'd0;
         ring_id_r  <= '0;
         ring_r     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         snz_cnt_r  <= 4'd0;
`endif
      end else begin
         state_r    <= state_n;
         ring_cnt_r <= ring_cnt_n;
         ring_id_r  <= ring_id_n;
         ring_r     <= (state_n == RING);
`ifdef ALARM_SNOOZE_EN
         snz_cnt_r  <= snz_cnt_n;
`endif
      end
   end

   assign Ring      = ring_r;
   assign RingId    = ring_id_r;
   assign dbg_state = state_r;

endmodule

// File: tb/tb_alarm_bank.sv
// -----------------------------------------------------------------------------
// tb_alarm_bank
//   Directed scenarios plus a randomized operation stream, checked against a
//   reference model that keeps alarm times as plain integers (hour 0..23,
//   minute 0..59) and a small ring/snooze state variable.
// -----------------------------------------------------------------------------
module tb_alarm_bank;

   localparam int N    = 4;
   localparam int SW   = 3;
   localparam int RMIN = 1;
   localparam int SMIN = 5;

   logic          Clk = 1'b0;
   logic          RST, EN, Btn_Hour, Btn_Min, Mode, MinTick, Stop, Snooze;
   logic [SW-1:0] Sel;
   logic [N-1:0]  Arm;
   logic [7:0]    CurHour, CurMin, AlertHour, AlertMin;
   logic          APM, Ring;
   logic [SW-1:0] RingId;
   alarm_pkg::alarm_state_t dbg_state;

   int checks = 0;
   int errors = 0;

   // reference model
   int mh [N];
   int mm [N];
   int st;   // 0 idle, 1 ringing, 2 snoozing
   int rc, sc, rid;

   logic [7:0] exp_q [$];

   alarm_bank #(
      .N_ALARMS(N), .SEL_W(SW), .RING_MIN(RMIN), .SNOOZE_MIN(SMIN)
   ) dut (
      .Clk(Clk), .RST(RST), .EN(EN), .Sel(Sel), .Btn_Hour(Btn_Hour),
      .Btn_Min(Btn_Min), .Arm(Arm), .Mode(Mode), .CurHour(CurHour),
      .CurMin(CurMin), .MinTick(MinTick), .Stop(Stop), .Snooze(Snooze),
      .AlertHour(AlertHour), .AlertMin(AlertMin), .APM(APM), .Ring(Ring),
      .RingId(RingId), .dbg_state(dbg_state)
   );

   // ------------------------------------------------------------ clock/reset
   always #5 Clk = ~Clk;

   initial begin
      #3000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ------------------------------------------------------------ model helpers
   function automatic logic [7:0] bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic logic [8:0] disp_hour(input int sel, input logic mode);
      int h;
      if (sel >= N) return 9'd0;
      h = mh[sel];
      if (!mode)   return {1'b0, bcd(h)};
      if (h == 0)  return {1'b0, bcd(12)};
      if (h < 12)  return {1'b0, bcd(h)};
      if (h == 12) return {1'b1, bcd(12)};
      return {1'b1, bcd(h - 12)};
   endfunction

   function automatic logic [7:0] disp_min(input int sel);
      if (sel >= N) return 8'h00;
      return bcd(mm[sel]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mh[i] = 0;
         mm[i] = 0;
      end
      st = 0; rc = 0; sc = 0; rid = 0;
   endtask

   // ------------------------------------------------------------ drivers
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic press(input int sel, input logic en, input logic h, input logic m);
      Sel = SW'(sel); EN = en; Btn_Hour = h; Btn_Min = m;
      step();
      Btn_Hour = 1'b0; Btn_Min = 1'b0;
      if (en && sel < N) begin
         if (h) mh[sel] = (mh[sel] + 1) % 24;
         if (m) mm[sel] = (mm[sel] + 1) % 60;
      end
      step();
   endtask

   task automatic set_alarm(input int sel, input int h, input int m);
      while (mh[sel] != h) press(sel, 1'b1, 1'b1, 1'b0);
      while (mm[sel] != m) press(sel, 1'b1, 1'b0, 1'b1);
   endtask

   // Leaves MinTick low after one active edge; outputs are then the post-edge values.
   task automatic tick(input int h, input int m);
      CurHour = bcd(h); CurMin = bcd(m); MinTick = 1'b1;
      step();
      MinTick = 1'b0;
      if (st == 0) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (Arm[i] && mh[i] == h && mm[i] == m) begin
               st = 1; rc = RMIN; rid = i;
            end
         end
      end else if (st == 1) begin
         rc = rc - 1;
         if (rc == 0) st = 0;
      end else begin
         sc = sc - 1;
         if (sc == 0) begin
            st = 1; rc = RMIN;
         end
      end
   endtask

   task automatic pulse_stop();
      Stop = 1'b1;
      step();
      Stop = 1'b0;
      st = 0;
   endtask

   task automatic pulse_snooze();
      Snooze = 1'b1;
      step();
      Snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
      if (st == 1) begin
         st = 2; sc = SMIN;
      end
`endif
   endtask

   task automatic set_arm(input logic [N-1:0] a);
      Arm = a;
      step();
      if (st != 0 && !a[rid]) st = 0;
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      RST = 1'b1;
      step(); step();
      RST = 1'b0;
      model_reset();
      checks++; if (Ring !== 1'b0) begin errors++; $display("FAIL reset_ring: got %b want 0", Ring); end
      checks++; if (RingId !== '0) begin errors++; $display("FAIL reset_ringid: got %0d want 0", RingId); end
      for (int s = 0; s < 8; s++) begin
         Sel = SW'(s); Mode = 1'b0; #1;
         checks++; if ({APM, AlertHour, AlertMin} !== 17'd0) begin
            errors++; $display("FAIL reset_disp24 sel%0d: got %b %h:%h want 0 00:00", s, APM, AlertHour, AlertMin);
         end
         Mode = 1'b1; #1;
         checks++; if ({APM, AlertHour} !== ((s < N) ? {1'b0, 8'h12} : 9'd0)) begin
            errors++; $display("FAIL reset_disp12 sel%0d: got %b %h", s, APM, AlertHour);
         end
      end
      Mode = 1'b0;
   endtask

   task automatic test_min_sweep();
      logic [7:0] e;
      for (int k = 1; k <= 60; k++) exp_q.push_back(bcd(k % 60));
      for (int k = 1; k <= 60; k++) begin
         press(1, 1'b1, 1'b0, 1'b1);
         e = exp_q.pop_front();
         checks++; if (AlertMin !== e) begin errors++; $display("FAIL min_sweep step%0d: got %h want %h", k, AlertMin, e); end
      end
      checks++; if (AlertHour !== 8'h00) begin errors++; $display("FAIL min_no_carry: hour got %h want 00", AlertHour); end
   endtask

   task automatic test_hour_12h();
      for (int k = 0; k < 13; k++) press(2, 1'b1, 1'b1, 1'b0);
      Mode = 1'b1; #1;
      checks++; if ({APM, AlertHour} !== {1'b1, 8'h01}) begin errors++; $display("FAIL h13_12h: got %b %h want 1 01", APM, AlertHour); end
      Mode = 1'b0; #1;
      checks++; if ({APM, AlertHour} !== {1'b0, 8'h13}) begin errors++; $display("FAIL h13_24h: got %b %h want 0 13", APM, AlertHour); end
      for (int k = 1; k <= 24; k++) begin
         press(3, 1'b1, 1'b1, 1'b0);
         Mode = 1'b0; #1;
         checks++; if ({APM, AlertHour} !== disp_hour(3, 1'b0)) begin errors++; $display("FAIL hsweep24 k%0d: got %b %h want %h", k, APM, AlertHour, disp_hour(3, 1'b0)); end
         Mode = 1'b1; #1;
         checks++; if ({APM, AlertHour} !== disp_hour(3, 1'b1)) begin errors++; $display("FAIL hsweep12 k%0d: got %b %h want %h", k, APM, AlertHour, disp_hour(3, 1'b1)); end
      end
      Mode = 1'b0;
      // both buttons in one cycle, then out-of-range and disabled edits
      press(0, 1'b1, 1'b1, 1'b1);
      Sel = 3'd0; #1;
      checks++; if ({AlertHour, AlertMin} !== {8'h01, 8'h01}) begin errors++; $display("FAIL both_btn: got %h:%h want 01:01", AlertHour, AlertMin); end
      press(5, 1'b1, 1'b1, 1'b1);
      Sel = 3'd5; #1;
      checks++; if ({APM, AlertHour, AlertMin} !== 17'd0) begin errors++; $display("FAIL sel_oob: got %b %h:%h want 0 00:00", APM, AlertHour, AlertMin); end
      press(0, 1'b0, 1'b1, 1'b1);
      Sel = 3'd0; #1;
      checks++; if ({AlertHour, AlertMin} !== {8'h01, 8'h01}) begin errors++; $display("FAIL en_low: got %h:%h want 01:01", AlertHour, AlertMin); end
      EN = 1'b1;
   endtask

   task automatic test_match();
      set_alarm(0, 7, 30);
      set_alarm(2, 7, 30);
      set_arm(4'b0101);
      tick(7, 30);
      checks++; if (Ring !== 1'b1) begin errors++; $display("FAIL match_ring: got %b want 1", Ring); end
      checks++; if (RingId !== 3'd0) begin errors++; $display("FAIL match_prio: got %0d want 0", RingId); end
      step();
      checks++; if (Ring !== 1'b1) begin errors++; $display("FAIL ring_hold: got %b want 1", Ring); end
      tick(7, 31);
      checks++; if (Ring !== 1'b0) begin errors++; $display("FAIL ring_expire: got %b want 0", Ring); end
      step();
      set_arm(4'b0100);
      tick(7, 30);
      checks++; if (Ring !== 1'b1 || RingId !== 3'd2) begin errors++; $display("FAIL match_id2: got %b/%0d want 1/2", Ring, RingId); end
      step();
      set_arm(4'b0000);
      checks++; if (Ring !== 1'b0) begin errors++; $display("FAIL disarm: got %b want 0", Ring); end
      set_arm(4'b0101);
   endtask

   task automatic test_stop();
      tick(7, 30);
      step();
      press(0, 1'b1, 1'b0, 1'b1);
      checks++; if (Ring !== 1'b1) begin errors++; $display("FAIL edit_keeps_ring: got %b want 1", Ring); end
`ifndef ALARM_SNOOZE_EN
      pulse_snooze();
      step();
      checks++; if (Ring !== 1'b1) begin errors++; $display("FAIL snooze_ignored: got %b want 1", Ring); end
`endif
      pulse_stop();
      checks++; if (Ring !== 1'b0) begin errors++; $display("FAIL stop: got %b want 0", Ring); end
      step();
      tick(7, 30);
      checks++; if (Ring !== 1'b1 || RingId !== SW'(rid) || rid != 2) begin errors++; $display("FAIL ring_id2_again: got %b/%0d want 1/2", Ring, RingId); end
      step();
      tick(7, 30);
      checks++; if (Ring !== 1'b0) begin errors++; $display("FAIL no_retrigger: got %b want 0", Ring); end
      step();
      checks++; if (Ring !== 1'b0) begin errors++; $display("FAIL no_retrigger_hold: got %b want 0", Ring); end
   endtask

`ifdef ALARM_SNOOZE_EN
   task automatic test_snooze();
      set_alarm(0, 7, 30);
      tick(7, 30);
      step();
      pulse_snooze();
      checks++; if (Ring !== 1'b0) begin errors++; $display("FAIL snooze_enter: got %b want 0", Ring); end
      step();
      for (int k = 1; k <= SMIN; k++) begin
         tick(7, 40 + k);
         checks++; if (Ring !== (k == SMIN) || RingId !== 3'd0) begin
            errors++; $display("FAIL snooze_tick%0d: got %b/%0d want %b/0", k, Ring, RingId, k == SMIN);
         end
         step();
      end
      pulse_snooze();
      step();
      pulse_stop();
      step();
      tick(8, 0);
      checks++; if (Ring !== 1'b0) begin errors++; $display("FAIL snooze_stop: got %b want 0", Ring); end
      step();
      tick(7, 30);
      step();
      Stop = 1'b1; Snooze = 1'b1;
      step();
      Stop = 1'b0; Snooze = 1'b0;
      st = 0;
      step();
      for (int k = 1; k <= SMIN; k++) begin
         tick(8, k);
         checks++; if (Ring !== 1'b0) begin errors++; $display("FAIL stop_wins tick%0d: got %b want 0", k, Ring); end
         step();
      end
   endtask
`endif

   task automatic test_reset_mid_ring();
      set_alarm(0, 7, 30);
      tick(7, 30);
      checks++; if (Ring !== 1'b1) begin errors++; $display("FAIL pre_rst_ring: got %b want 1", Ring); end
      RST = 1'b1;
      step();
      RST = 1'b0;
      model_reset();
      checks++; if (Ring !== 1'b0 || RingId !== '0) begin errors++; $display("FAIL rst_mid_ring: got %b/%0d want 0/0", Ring, RingId); end
      for (int s = 0; s < N; s++) begin
         Sel = SW'(s); #1;
         checks++; if ({AlertHour, AlertMin} !== 16'h0000) begin errors++; $display("FAIL rst_clear sel%0d: got %h:%h want 00:00", s, AlertHour, AlertMin); end
      end
      for (int k = 0; k < 3; k++) press(1, 1'b0, 1'b1, 1'b1);
      Sel = 3'd1; #1;
      checks++; if ({AlertHour, AlertMin} !== 16'h0000) begin errors++; $display("FAIL en0_edges: got %h:%h want 00:00", AlertHour, AlertMin); end
      EN = 1'b1;
   endtask

   task automatic test_random();
      int op, s, h, m;
      for (int n = 0; n < 400; n++) begin
         op = $urandom_range(0, 7);
         case (op)
            0: press($urandom_range(0, 7), ($urandom_range(0, 3) != 0), 1'b1, 1'b0);
            1: press($urandom_range(0, 7), ($urandom_range(0, 3) != 0), 1'b0, 1'b1);
            2: press($urandom_range(0, 7), ($urandom_range(0, 3) != 0), 1'b1, 1'b1);
            3: begin
               if ($urandom_range(0, 1) == 1) begin
                  s = $urandom_range(0, N - 1);
                  h = mh[s]; m = mm[s];
               end else begin
                  h = $urandom_range(0, 23); m = $urandom_range(0, 59);
               end
               tick(h, m);
               step();
            end
            4: begin pulse_stop(); step(); end
            5: begin pulse_snooze(); step(); end
            6: set_arm(N'($urandom_range(0, (1 << N) - 1)));
            default: Mode = 1'($urandom_range(0, 1));
         endcase
         s = $urandom_range(0, 7);
         Sel = SW'(s); #1;
         checks++; if (Ring !== (st == 1)) begin errors++; $display("FAIL rnd_ring op%0d n%0d: got %b want %b", op, n, Ring, st == 1); end
         checks++; if (RingId !== SW'(rid)) begin errors++; $display("FAIL rnd_ringid n%0d: got %0d want %0d", n, RingId, rid); end
         checks++; if ({APM, AlertHour} !== disp_hour(s, Mode)) begin errors++; $display("FAIL rnd_hour n%0d sel%0d: got %b %h want %h", n, s, APM, AlertHour, disp_hour(s, Mode)); end
         checks++; if (AlertMin !== disp_min(s)) begin errors++; $display("FAIL rnd_min n%0d sel%0d: got %h want %h", n, s, AlertMin, disp_min(s)); end
      end
   endtask

   // ------------------------------------------------------------ sequence + report
   initial begin
      RST = 1'b1; EN = 1'b1; Sel = '0; Btn_Hour = 1'b0; Btn_Min = 1'b0;
      Arm = '0; Mode = 1'b0; CurHour = 8'h00; CurMin = 8'h00;
      MinTick = 1'b0; Stop = 1'b0; Snooze = 1'b0;
      model_reset();
      test_reset();
      test_min_sweep();
      test_hour_12h();
      test_match();
      test_stop();
`ifdef ALARM_SNOOZE_EN
      test_snooze();
`endif
      test_reset_mid_ring();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
